// File: rtl/alu_pkg.sv
// alu_pkg: shared types and default constants for the ALU result collector.
//   data_t            - 8-bit ALU result word
//   collector_state_t - collector FSM states
//   COLLECTOR_*       - default DEPTH / CLR_CYCLES / TIMEOUT values
//   sat_inc8          - saturating 8-bit increment used by the drop counter
package alu_pkg;

  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } collector_state_t;

  localparam int unsigned COLLECTOR_DEPTH      = 4;
  localparam int unsigned COLLECTOR_CLR_CYCLES = 2;
  localparam int unsigned COLLECTOR_TIMEOUT    = 15;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if: result stream from the collector to its consumer.
//   res_valid - FIFO head valid            (collector -> consumer)
//   res_ready - consumer accepts the head  (consumer -> collector)
//   res_data  - FIFO head data             (collector -> consumer)
//   res_count - FIFO occupancy             (collector -> consumer)
// Modports: master = collector side, slave = consumer side.
interface alu_result_collector_if
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = COLLECTOR_DEPTH
);

  logic                     res_valid;
  logic                     res_ready;
  data_t                    res_data;
  logic [$clog2(DEPTH):0]   res_count;

  modport master (
    output res_valid,
    output res_data,
    output res_count,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_count,
    output res_ready
  );

endinterface

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: first-word-fall-through result FIFO.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push_i       - push request (one word, push_data_i)
//   push_data_i  - word to push
//   drop_o       - push refused because full with no same-cycle pop
//   res          - head/valid/count/ready stream (master modport)
// A push into a full FIFO still succeeds when the head is popped on the
// same edge. res_data is forced to zero while empty so the stream reads
// zero out of reset.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = COLLECTOR_DEPTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  data_t push_data_i,
  output logic  drop_o,
  alu_result_collector_if.master res
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  data_t          mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           empty, full, pop, wr_en;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign pop    = res.res_ready && !empty;
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + PW'(1);
    if (pop)   rptr_d = rptr_q + PW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= push_data_i;
  end

  assign res.res_valid = !empty;
  assign res.res_data  = empty ? '0 : mem_q[rptr_q];
  assign res.res_count = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: captures ALU results on interrupt, acknowledges the
// ALU with a clear pulse and queues results for a consumer.
//   clk         - clock, rising edge
//   alu_rst_n   - asynchronous active-low reset
//   alu_out     - ALU result, sampled on the CAPTURE edge
//   alu_irq     - ALU interrupt request (level)
//   alu_irq_clr - registered clear pulse, CLR_CYCLES wide
//   overflow    - sticky, a capture was dropped on a full FIFO
//   drop_cnt    - dropped-capture count, saturating at 255
//   stuck_err   - sticky, alu_irq stayed high for TIMEOUT cycles after clear
//   err_clr     - clears overflow, drop_cnt and stuck_err
//   res         - result stream (master modport)
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH      = COLLECTOR_DEPTH,
  parameter int unsigned CLR_CYCLES = COLLECTOR_CLR_CYCLES,
  parameter int unsigned TIMEOUT    = COLLECTOR_TIMEOUT
) (
  input  logic       clk,
  input  logic       alu_rst_n,
  input  data_t      alu_out,
  input  logic       alu_irq,
  output logic       alu_irq_clr,
  output logic       overflow,
  output logic [7:0] drop_cnt,
  output logic       stuck_err,
  input  logic       err_clr,
  alu_result_collector_if.master res
);

  localparam int unsigned CCW = $clog2(CLR_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  collector_state_t state_q, state_d;
  logic [CCW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             irq_clr_q, irq_clr_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             stuck_q, stuck_d;
  logic             push, stuck_evt, drop;

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (alu_rst_n),
    .push_i      (push),
    .push_data_i (alu_out),
    .drop_o      (drop),
    .res         (res)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    push      = 1'b0;
    stuck_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (alu_irq) state_d = CAPTURE;
      end
      CAPTURE: begin
        push      = 1'b1;
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
      CLEAR: begin
        if (clr_cnt_q == CCW'(CLR_CYCLES - 1)) begin
          state_d   = WAIT_LOW;
          tmo_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CCW'(1);
        end
      end
      WAIT_LOW: begin
        if (!alu_irq) begin
          state_d = IDLE;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          // Retry the clear without recapturing the same request.
          stuck_evt = 1'b1;
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered clear: high exactly while the FSM sits in CLEAR.
  assign irq_clr_d = (state_d == CLEAR);

  // An error event on the same edge as err_clr takes priority.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    stuck_d    = stuck_q;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = err_clr ? 8'd1 : sat_inc8(drop_cnt_q);
    end else if (err_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (stuck_evt)    stuck_d = 1'b1;
    else if (err_clr) stuck_d = 1'b0;
  end

  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      irq_clr_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      irq_clr_q  <= irq_clr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      stuck_q    <= stuck_d;
    end
  end

  assign alu_irq_clr = irq_clr_q;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;
  assign stuck_err   = stuck_q;

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 4, result FIFO entries; power of two, at least 2.
- CLR_CYCLES, 2, width in cycles of each alu_irq_clr pulse; at least 1.
- TIMEOUT, 15, cycles in WAIT_LOW before declaring the IRQ stuck; at least 1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- alu_rst_n, in, 1, reset; asynchronous, active-low.
- alu_out, in, 8, ALU result (data_t); sampled only on IRQ capture.
- alu_irq, in, 1, ALU interrupt request, level.
- alu_irq_clr, out, 1, IRQ clear pulse back to the ALU.
- res_valid, out, 1, FIFO head valid.
- res_ready, in, 1, consumer accepts the head.
- res_data, out, 8, FIFO head data.
- res_count, out, $clog2(DEPTH)+1, current FIFO occupancy.
- overflow, out, 1, sticky: a capture was dropped.
- drop_cnt, out, 8, dropped-capture count; saturates at 255.
- stuck_err, out, 1, sticky: IRQ still high after TIMEOUT.
- err_clr, in, 1, clears overflow, drop_cnt and stuck_err.

Function
REQ-003 FSM states: IDLE, CAPTURE, CLEAR, WAIT_LOW.
REQ-004 IDLE: the edge that samples alu_irq=1 moves to CAPTURE; otherwise stays in IDLE.
REQ-005 CAPTURE (one cycle): samples alu_out, requests a FIFO push, then goes to CLEAR.
REQ-006 CLEAR: alu_irq_clr=1 for exactly CLR_CYCLES cycles, then goes to WAIT_LOW.
REQ-007 WAIT_LOW: alu_irq_clr=0.
- alu_irq sampled 0: go to IDLE.
- TIMEOUT cycles elapse with alu_irq still 1: set stuck_err and go to CLEAR (retry); no new capture occurs.
REQ-008 alu_irq_clr is driven from a register and is never asserted outside CLEAR.
REQ-009 The FIFO is first-word-fall-through: pushed data appears on res_data with res_valid=1 on the cycle after the CAPTURE edge.
REQ-010 A pop occurs on any edge with res_valid and res_ready both 1.
- res_data must hold stable while res_valid=1 and res_ready=0.
REQ-011 Read and write pointers wrap modulo DEPTH.
- res_count is updated in the same cycle as the push or pop.
REQ-012 Push and pop in the same cycle: both complete, count is unchanged; this also holds when the FIFO is full.
REQ-013 Push while full without a same-cycle pop: data is dropped, FIFO contents are unchanged, overflow=1, drop_cnt increments (saturating at 255).
REQ-014 Pop while empty has no effect.
REQ-015 err_clr=1 zeroes overflow, drop_cnt and stuck_err on the next edge.
- If err_clr and an error event coincide, the event wins: the flag is set, or drop_cnt is set to 1.

Reset
REQ-016 While alu_rst_n=0 (asynchronous, takes effect immediately):
- FSM forced to IDLE.
- Pointers, res_count, timers and counters cleared to 0.
- All outputs 0, including alu_irq_clr.
REQ-017 Reset in the middle of CLEAR aborts the pulse immediately; FIFO data is discarded.
REQ-018 The first capture can occur on the first edge after alu_rst_n returns to 1 with alu_irq=1.

Structure
REQ-019 alu_pkg shall hold:
- collector_state_t (the FSM enum).
- COLLECTOR_DEPTH, COLLECTOR_CLR_CYCLES and COLLECTOR_TIMEOUT default constants.
- res_data reuses data_t from the package.
REQ-020 The FIFO shall be a sub-module, alu_res_fifo: storage, pointers, count and FWFT head.
- The top level keeps the FSM, timers and error logic.

Verification
REQ-021 The bench shall cover these directed scenarios:
- Single capture: alu_out=8'hFF, alu_irq rises and the ALU drops it 2 cycles after clr. Required: alu_irq_clr high exactly 2 cycles, then res_valid=1 with res_data=8'hFF, res_count=1.
- Fill and overflow: 5 IRQs (8'h00, 8'hF8, 8'h83, 8'hF1, 8'hF4), res_ready=0. Required: res_count=4, overflow=1, drop_cnt=1, pops return 8'h00, 8'hF8, 8'h83, 8'hF1 in that order.
- Full, simultaneous push/pop: res_ready=1 on the CAPTURE edge. Required: no drop, count stays 4, new value at the tail.
- Stuck IRQ: alu_irq held 1 for 40 cycles. Required: stuck_err=1 after 2+15 cycles, a second clr pulse follows, and exactly one FIFO entry is pushed.
- Reset mid-CLEAR: alu_rst_n=0 during the pulse. Required: alu_irq_clr=0 immediately, res_count=0, FSM in IDLE.
- err_clr coinciding with an overflow drop. Required: overflow stays 1, drop_cnt=1.
